pc_update_seq: RTL and testbench
================================

PC_UPDATE_SEQ -- requirements
Module: pc_update_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64: width of all address and value buses.
REQ-002 The block SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 8, power of two >= 2: return-address-stack entries.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port opcode, input, 8: icode in [7:4], ifun in [3:0] of the current instruction.
REQ-007 The block SHALL have ports valP, valC and valM, input, ADDR_W each: fall-through address, constant/destination, and memory-read value.
REQ-008 The block SHALL have port Cnd, input, 1: branch condition from execute.
REQ-009 The block SHALL have port stall, input, 1: freeze all state this cycle.
REQ-010 The block SHALL have port pc, output, ADDR_W: registered program counter.
REQ-011 The block SHALL have port status, output, 2: 00 AOK, 01 HLT, 10 INS, 11 unused.
REQ-012 The block SHALL have port ras_top, output, ADDR_W: current RAS top entry, or 0 when empty.
REQ-013 The block SHALL have port ras_miss, output, 1: registered one-cycle pulse on a ret misprediction.

Function
REQ-014 The state machine SHALL have states RUN, HLT and INS; status SHALL encode the current state.
REQ-015 In RUN with stall=0, the next pc SHALL be selected by icode:
- 7 (jXX): valC if Cnd=1, else valP.
- 8 (call): valC.
- 9 (ret): valM.
- 1..6, A, B: valP.
REQ-016 In RUN with stall=0, icode 0 SHALL move the state to HLT and hold pc.
REQ-017 In RUN with stall=0, icode C..F SHALL move the state to INS and hold pc.
REQ-018 In HLT or INS, pc, the RAS and the state SHALL hold until reset; opcode SHALL be ignored.
REQ-019 With stall=1:
- pc, state, RAS pointer and RAS contents SHALL hold.
- ras_miss SHALL be 0.
REQ-020 pc SHALL update one clock edge after the inputs are sampled; there is no combinational path from inputs to pc.
REQ-021 Next-pc arithmetic SHALL be a pure selection; no addition is performed and there is no wrap handling.
REQ-022 Cnd SHALL be ignored for every icode other than 7.

Reset
REQ-023 While rst_n=0, asynchronously and independent of clk:
- pc=RESET_PC, state=RUN, status=00.
- RAS count=0, ras_top=0, ras_miss=0.
REQ-024 Reset asserted mid-operation, including during stall, HLT or INS, SHALL take priority over all other inputs.
REQ-025 The first rising edge after rst_n deasserts SHALL evaluate normally.

Configuration
REQ-026 The RAS SHALL be compiled in only when macro PC_UPDATE_SEQ_RAS_EN is defined.
REQ-027 With PC_UPDATE_SEQ_RAS_EN defined:
- call (un-stalled, RUN) SHALL push valP.
- ret SHALL pop, and pulse ras_miss=1 on the next cycle if the popped value != valM, or if the stack was empty.
- A push when full SHALL overwrite the oldest entry (circular) with count saturating at RAS_DEPTH.
- The architectural pc SHALL always take valM on ret.
REQ-028 Without PC_UPDATE_SEQ_RAS_EN, no RAS storage SHALL exist and ras_top and ras_miss SHALL be constant 0.

Verification
REQ-029 Reset: rst_n=0 with ADDR_W=64, RESET_PC=0 -> pc=0, status=00, ras_top=0 with no clk edge required.
REQ-030 Branch: opcode=0x74, valP=10000, valC=90, Cnd=0 -> pc=10000 after the edge; then valP=100010, Cnd=1 -> pc=90.
REQ-031 Call/ret (RAS_EN): opcode=0x80, valC=400, valP=209 -> pc=400, ras_top=209; then opcode=0x90, valM=209 -> pc=209, ras_miss=0, ras_top=0.
REQ-032 Stall: pc=90, stall=1, opcode=0x20, valP=890 -> pc stays 90 for 3 cycles; stall=0 -> pc=890 on the next edge.
REQ-033 Halt/invalid:
- opcode=0x00 -> status=01, pc held; a following opcode=0x20 is ignored.
- After reset, opcode=0xC0 -> status=10.
REQ-034 RAS wrap (RAS_EN, depth 8): 9 calls with valP=1..9, then 9 rets with matching valM=9..1 -> the first 8 rets give ras_miss=0; the 9th ret (valM=1, stack empty) gives ras_miss=1.

Source files
------------

// File: rtl/pc_update_seq.sv
// PC sequencer: next-pc select, RUN/HLT/INS state and optional return-address stack.
// Define PC_UPDATE_SEQ_RAS_EN to build the RAS; otherwise ras_top/ras_miss tie to 0.
module pc_update_seq #(
  parameter int                 ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        opcode,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valM,
  input  logic              Cnd,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_miss
);

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_HLT = 2'b01,
    ST_INS = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        icode;
  logic              push, pop;

  assign icode = opcode[7:4];

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == ST_RUN && !stall) begin
      unique case (1'b1)
        icode == 4'h0: state_d = ST_HLT;
        icode >= 4'hC: state_d = ST_INS;
        icode == 4'h7: pc_d = Cnd ? valC : valP;
        icode == 4'h8: begin
          pc_d = valC;
          push = 1'b1;
        end
        icode == 4'h9: begin
          pc_d = valM;
          pop  = 1'b1;
        end
        default: pc_d = valP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc     = pc_q;
  assign status = state_q;

`ifdef PC_UPDATE_SEQ_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]     ras_ptr_q;
  logic [PW:0]       ras_cnt_q;
  logic              ras_miss_q;
  logic [PW-1:0]     top_idx;
  logic [ADDR_W-1:0] top_val;
  logic              empty;

  // ptr is the next write slot; the top entry sits one below it
  assign top_idx = ras_ptr_q - 1'b1;
  assign top_val = ras_mem_q[top_idx];
  assign empty   = (ras_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      ras_miss_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
    end else begin
      ras_miss_q <= 1'b0;
      if (push) begin
        ras_mem_q[ras_ptr_q] <= valP;
        ras_ptr_q            <= ras_ptr_q + 1'b1;
        if (ras_cnt_q != CNT_MAX) ras_cnt_q <= ras_cnt_q + 1'b1;
      end else if (pop) begin
        ras_miss_q <= empty || (top_val != valM);
        if (!empty) begin
          ras_ptr_q <= top_idx;
          ras_cnt_q <= ras_cnt_q - 1'b1;
        end
      end
    end
  end

  assign ras_top  = empty ? '0 : top_val;
  assign ras_miss = ras_miss_q;
`else
  logic unused_ras;
  assign unused_ras = ^{push, pop};
  assign ras_top    = '0;
  assign ras_miss   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_update_seq.sv
// Directed bench for pc_update_seq (default params).
// RAS expectations follow PC_UPDATE_SEQ_RAS_EN.
module tb_pc_update_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  opcode;
  logic [63:0] valP, valC, valM;
  logic        Cnd, stall;
  logic [63:0] pc, ras_top;
  logic [1:0]  status;
  logic        ras_miss;

  int n_tot  = 0;
  int n_pass = 0;

`ifdef PC_UPDATE_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  pc_update_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .valP     (valP),
    .valC     (valC),
    .valM     (valM),
    .Cnd      (Cnd),
    .stall    (stall),
    .pc       (pc),
    .status   (status),
    .ras_top  (ras_top),
    .ras_miss (ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 8'h10;
    valP   = '0;
    valC   = '0;
    valM   = '0;
    Cnd    = 1'b0;
    stall  = 1'b0;
    #1;
    chk("rst_pc", pc, 64'd0);
    chk("rst_status", {62'd0, status}, 64'd0);
    chk("rst_top", ras_top, 64'd0);
    chk("rst_miss", {63'd0, ras_miss}, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // branch not taken then taken
    opcode = 8'h74; valP = 64'd10000; valC = 64'd90; Cnd = 1'b0;
    step();
    chk("jxx_nt", pc, 64'd10000);
    valP = 64'd100010; Cnd = 1'b1;
    step();
    chk("jxx_t", pc, 64'd90);
    chk("run_status", {62'd0, status}, 64'd0);

    // stall holds pc for three edges
    stall = 1'b1; opcode = 8'h20; valP = 64'd890;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_pc%0d", i), pc, 64'd90);
      chk($sformatf("stall_miss%0d", i), {63'd0, ras_miss}, 64'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", pc, 64'd890);

    // Cnd ignored for non-jump
    opcode = 8'h30; valP = 64'd77; valC = 64'd5; Cnd = 1'b1;
    step();
    chk("cnd_ign", pc, 64'd77);
    Cnd = 1'b0;

    // call / ret
    opcode = 8'h80; valC = 64'd400; valP = 64'd209;
    step();
    chk("call_pc", pc, 64'd400);
    chk("call_top", ras_top, RAS ? 64'd209 : 64'd0);
    opcode = 8'h90; valM = 64'd209;
    step();
    chk("ret_pc", pc, 64'd209);
    chk("ret_miss", {63'd0, ras_miss}, 64'd0);
    chk("ret_top", ras_top, 64'd0);

    // nine calls into an 8-deep stack, then nine rets
    for (int i = 1; i <= 9; i++) begin
      opcode = 8'h80; valP = 64'(i); valC = 64'(1000 + i);
      step();
      chk($sformatf("wcall_pc%0d", i), pc, 64'(1000 + i));
    end
    chk("wrap_top", ras_top, RAS ? 64'd9 : 64'd0);
    for (int i = 9; i >= 1; i--) begin
      opcode = 8'h90; valM = 64'(i);
      step();
      chk($sformatf("wret_pc%0d", i), pc, 64'(i));
      chk($sformatf("wret_miss%0d", i), {63'd0, ras_miss},
          (RAS && i == 1) ? 64'd1 : 64'd0);
    end

    // mismatching ret, then pulse must drop
    opcode = 8'h80; valP = 64'd50; valC = 64'd600;
    step();
    opcode = 8'h90; valM = 64'd51;
    step();
    chk("mis_pc", pc, 64'd51);
    chk("mis_miss", {63'd0, ras_miss}, RAS ? 64'd1 : 64'd0);
    opcode = 8'h10; valP = 64'd52;
    step();
    chk("mis_drop", {63'd0, ras_miss}, 64'd0);
    chk("nop_pc", pc, 64'd52);

    // halt freezes pc and ignores later opcodes
    opcode = 8'h00;
    step();
    chk("hlt_status", {62'd0, status}, 64'd1);
    chk("hlt_pc", pc, 64'd52);
    opcode = 8'h20; valP = 64'd555;
    step();
    chk("hlt_hold", pc, 64'd52);
    chk("hlt_hold_st", {62'd0, status}, 64'd1);

    // async reset mid-cycle with stall high
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 64'd0);
    chk("arst_status", {62'd0, status}, 64'd0);
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    opcode = 8'h10; valP = 64'd44;
    step();
    chk("first_edge", pc, 64'd44);

    // invalid instruction
    opcode = 8'hC0; valP = 64'd66;
    step();
    chk("ins_status", {62'd0, status}, 64'd2);
    chk("ins_pc", pc, 64'd44);
    opcode = 8'h20; valP = 64'd70;
    step();
    chk("ins_hold", pc, 64'd44);
    chk("ins_hold_st", {62'd0, status}, 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
